// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID->EX pipeline register with stall/flush, load detect and a saturating bubble counter.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic                  JalrmuxSelD,
    input  logic [2:0]            ALUControlD,
    input  logic [2:0]            Funct3D,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            RdD,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ALUSrcE,
    output logic                  JalrmuxSelE,
    output logic [2:0]            ALUControlE,
    output logic [2:0]            Funct3E,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE,
    output logic                  ValidE,
    output logic                  MemReadE,
    output logic [CNT_WIDTH-1:0]  BubbleCount
);
    localparam int CW = 14;
    localparam int DW = 5 * DATA_WIDTH + 15;
    logic [CW-1:0]        w_ctl_d, r_ctl;
    logic [DW-1:0]        w_data_d, r_data;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_bubble;
    assign w_ctl_d  = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, JalrmuxSelD, ALUControlD, Funct3D};
    assign w_data_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
    assign w_bubble = FlushE || (!StallE && !ValidD);
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            r_ctl   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (!StallE) begin
            r_ctl   <= ValidD ? w_ctl_d : '0;
            r_data  <= w_data_d;
            r_valid <= ValidD;
        end
    end
    // Counter saturates at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (w_bubble && r_count != '1)
            r_count <= r_count + 1'b1;
    end
    assign {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrmuxSelE, ALUControlE, Funct3E} = r_ctl;
    assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE} = r_data;
    assign ValidE      = r_valid;
    assign MemReadE    = RegWriteE && (ResultSrcE == 2'b01);
    assign BubbleCount = r_count;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: vector table, saturation sequence and randomized model check for id_ex_pipeline_reg.
module tb_id_ex_pipeline_reg;
    localparam int CW = 4;
    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw, j, b, as, jm;
        logic [2:0]  alu, f3;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  r1, r2, rd;
    } d_t;
    typedef struct {
        logic rst, flush, stall, valid;
        d_t   d, e;
        logic ev, emr;
        int   cnt;
    } vec_t;

    logic clk = 0, rst, StallE, FlushE, ValidD;
    d_t d_in, e_out;
    logic ValidE, MemReadE;
    logic [CW-1:0] BubbleCount;
    logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrmuxSelE;
    logic [1:0] ResultSrcE;
    logic [2:0] ALUControlE, Funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0] Rs1E, Rs2E, RdE;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(d_in.rw), .ResultSrcD(d_in.rs), .MemWriteD(d_in.mw), .JumpD(d_in.j),
        .BranchD(d_in.b), .ALUSrcD(d_in.as), .JalrmuxSelD(d_in.jm), .ALUControlD(d_in.alu),
        .Funct3D(d_in.f3), .RD1D(d_in.rd1), .RD2D(d_in.rd2), .PCD(d_in.pc), .PCPlus4D(d_in.pc4),
        .ImmExtD(d_in.imm), .Rs1D(d_in.r1), .Rs2D(d_in.r2), .RdD(d_in.rd),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .JalrmuxSelE(JalrmuxSelE), .ALUControlE(ALUControlE),
        .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .MemReadE(MemReadE), .BubbleCount(BubbleCount)
    );

    assign e_out = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrmuxSelE,
                    ALUControlE, Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

    function automatic d_t strip(d_t x);
        x.rw = 0; x.rs = 0; x.mw = 0; x.j = 0; x.b = 0; x.as = 0; x.jm = 0; x.alu = 0; x.f3 = 0;
        return x;
    endfunction

    function automatic vec_t mk(logic r, logic f, logic s, logic v, d_t d, d_t e, logic ev, logic emr, int cnt);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.valid = v; t.d = d; t.e = e; t.ev = ev; t.emr = emr; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(string n, logic [255:0] got, logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic step(logic r, logic f, logic s, logic v, d_t d);
        @(negedge clk);
        rst = r; FlushE = f; StallE = s; ValidD = v; d_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        d_t z, addi, lw, sw, beq, jal, inv, rnd;
        d_t m_e;
        logic m_v;
        int m_c;
        logic [191:0] bits;
        vec_t tv[14];
        z = '0;
        addi = '0; addi.rw = 1; addi.as = 1; addi.imm = 5; addi.rd = 5'd3; addi.rd1 = 32'h11; addi.pc = 32'h100; addi.pc4 = 32'h104;
        lw = '0; lw.rw = 1; lw.rs = 2'b01; lw.as = 1; lw.f3 = 3'b010; lw.rd = 5'd4; lw.imm = 8;
        sw = '0; sw.mw = 1; sw.rs = 2'b01; sw.as = 1; sw.f3 = 3'b010; sw.r2 = 5'd4; sw.rd2 = 32'hdead;
        beq = '0; beq.b = 1; beq.alu = 3'b001; beq.r1 = 5'd1; beq.r2 = 5'd2; beq.pc = 32'h200;
        jal = '0; jal.j = 1; jal.rs = 2'b10; jal.rw = 1; jal.rd = 5'd1; jal.pc4 = 32'h304;
        inv = '0; inv.rw = 1; inv.mw = 1; inv.rd1 = 32'h1234; inv.rd = 5'd7;
        tv[0]  = mk(1, 0, 0, 1, addi, z, 0, 0, 0);
        tv[1]  = mk(1, 0, 0, 1, addi, z, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 1, addi, addi, 1, 0, 0);
        tv[3]  = mk(0, 0, 0, 1, lw, lw, 1, 1, 0);
        tv[4]  = mk(0, 0, 0, 1, sw, sw, 1, 0, 0);
        tv[5]  = mk(0, 0, 0, 1, beq, beq, 1, 0, 0);
        tv[6]  = mk(0, 0, 1, 1, lw, beq, 1, 0, 0);
        tv[7]  = mk(0, 0, 1, 1, sw, beq, 1, 0, 0);
        tv[8]  = mk(0, 0, 1, 0, addi, beq, 1, 0, 0);
        tv[9]  = mk(0, 1, 1, 1, jal, z, 0, 0, 1);
        tv[10] = mk(0, 0, 0, 0, inv, strip(inv), 0, 0, 2);
        tv[11] = mk(0, 0, 0, 1, jal, jal, 1, 0, 2);
        tv[12] = mk(1, 1, 1, 1, lw, z, 0, 0, 0);
        tv[13] = mk(0, 0, 0, 1, addi, addi, 1, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(tv[i].rst, tv[i].flush, tv[i].stall, tv[i].valid, tv[i].d);
            chk($sformatf("vec%0d_e", i), 256'(e_out), 256'(tv[i].e));
            chk($sformatf("vec%0d_valid", i), 256'(ValidE), 256'(tv[i].ev));
            chk($sformatf("vec%0d_memread", i), 256'(MemReadE), 256'(tv[i].emr));
            chk($sformatf("vec%0d_cnt", i), 256'(BubbleCount), 256'(tv[i].cnt));
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 1, jal);
            chk($sformatf("sat%0d_cnt", i), 256'(BubbleCount), 256'((i + 1 < 15) ? i + 1 : 15));
        end
        step(0, 0, 1, 0, jal);
        chk("sat_stall_hold", 256'(BubbleCount), 256'(15));
        step(1, 0, 0, 1, jal);
        chk("sat_rst_cnt", 256'(BubbleCount), 256'(0));
        chk("sat_rst_e", 256'(e_out), 256'(z));
        m_e = '0; m_v = 0; m_c = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, f, s, v;
            bits = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rnd = bits[188:0];
            r = ($urandom_range(0, 29) == 0);
            f = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 4) != 0);
            if (r) begin
                m_e = '0; m_v = 0; m_c = 0;
            end else if (f) begin
                m_e = '0; m_v = 0; m_c = (m_c < 15) ? m_c + 1 : 15;
            end else if (!s) begin
                m_e = v ? rnd : strip(rnd);
                m_v = v;
                if (!v) m_c = (m_c < 15) ? m_c + 1 : 15;
            end
            step(r, f, s, v, rnd);
            chk($sformatf("rnd%0d_e", i), 256'(e_out), 256'(m_e));
            chk($sformatf("rnd%0d_valid", i), 256'(ValidE), 256'(m_v));
            chk($sformatf("rnd%0d_memread", i), 256'(MemReadE), 256'(m_e.rw && m_e.rs == 2'b01));
            chk($sformatf("rnd%0d_cnt", i), 256'(BubbleCount), 256'(m_c));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
